// File: rtl/sparse_pkg.sv
// Shared types and widths for the sparse weight encoder and address generation.
package sparse_pkg;
  localparam int NUM_GRP_DEF = 4;
  localparam int R_W   = 3;
  localparam int K_W   = 5;
  localparam int VAL_W = 8;
  localparam int PTR_W = 11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [R_W-1:0]   r;
    logic [K_W-1:0]   k;
    logic [VAL_W-1:0] val;
  } entry_t;

  // Group index width; a single group still needs one bit.
  function automatic int grp_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/swe_scan_ctr.sv
// Nested g/r/k scan counters: k fastest, then r, then g.
module swe_scan_ctr
  import sparse_pkg::*;
#(
  parameter int NUM_GRP = NUM_GRP_DEF,
  localparam int G_W    = grp_w(NUM_GRP)
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           clr,
  input  logic           adv,
  input  logic [R_W-1:0] num_r,
  input  logic [K_W-1:0] num_k,
  output logic [G_W-1:0] g,
  output logic [R_W-1:0] r,
  output logic [K_W-1:0] k,
  output logic           last_grp,
  output logic           last_all
);
  logic last_k, last_r;

  assign last_k   = (k == num_k - K_W'(1));
  assign last_r   = (r == num_r - R_W'(1));
  assign last_grp = last_k && last_r;
  assign last_all = last_grp && (g == G_W'(NUM_GRP - 1));

  // Advance one element per accepted weight; clear on a new job.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      g <= '0;
      r <= '0;
      k <= '0;
    end else if (clr) begin
      g <= '0;
      r <= '0;
      k <= '0;
    end else if (adv) begin
      if (!last_k) begin
        k <= k + K_W'(1);
      end else begin
        k <= '0;
        if (!last_r) begin
          r <= r + R_W'(1);
        end else begin
          r <= '0;
          g <= last_all ? '0 : g + G_W'(1);
        end
      end
    end
  end
endmodule

// File: rtl/sparse_weight_encoder.sv
// Compresses a dense weight stream into (r,k,val) entries with per-group end pointers.
module sparse_weight_encoder
  import sparse_pkg::*;
#(
  parameter int NUM_GRP     = NUM_GRP_DEF,
  parameter int MAX_ENTRIES = 1024
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [R_W-1:0]   i_num_r,
  input  logic [K_W-1:0]   i_num_k,
  input  logic             i_valid,
  input  logic [VAL_W-1:0] i_data,
  output logic             o_ready,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [R_W-1:0]   o_r,
  output logic [K_W-1:0]   o_k,
  output logic [VAL_W-1:0] o_val,
  output logic [PTR_W-1:0] o_ptr [0:NUM_GRP-1],
  output logic [PTR_W-1:0] o_len,
  output logic             o_finish,
  output logic             o_overflow,
  output logic             o_busy
);
  localparam int G_W = grp_w(NUM_GRP);
  localparam logic [PTR_W-1:0] MAX_L = PTR_W'(MAX_ENTRIES);

  state_t           state, state_nxt;
  logic [R_W-1:0]   num_r;
  logic [K_W-1:0]   num_k;
  logic [G_W-1:0]   g;
  logic [R_W-1:0]   r;
  logic [K_W-1:0]   k;
  logic             last_grp, last_all;
  entry_t           ent;
  logic             start_ok, accept, nz, full, store, drop;
  logic [PTR_W-1:0] len_nxt;

  assign start_ok = (state == S_IDLE) && i_start;
  assign accept   = i_valid && o_ready;
  assign nz       = (i_data != '0);
  assign full     = (o_len == MAX_L);
  assign store    = accept && nz && !full;
  assign drop     = accept && nz && full;
  // Group end pointer includes the element being accepted this cycle.
  assign len_nxt  = store ? o_len + PTR_W'(1) : o_len;

  assign o_r   = ent.r;
  assign o_k   = ent.k;
  assign o_val = ent.val;

  swe_scan_ctr #(.NUM_GRP(NUM_GRP)) u_ctr (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .clr      (start_ok),
    .adv      (accept),
    .num_r    (num_r),
    .num_k    (num_k),
    .g        (g),
    .r        (r),
    .k        (k),
    .last_grp (last_grp),
    .last_all (last_all)
  );

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; an empty kernel skips straight to done.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (i_start) state_nxt = (i_num_r == '0 || i_num_k == '0) ? S_DONE : S_SCAN;
      S_SCAN:  if (accept && last_all) state_nxt = S_DRAIN;
      S_DRAIN: if (!o_valid || i_ready) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake and status outputs derived from state.
  always_comb begin
    o_ready  = 1'b0;
    o_busy   = 1'b0;
    o_finish = 1'b0;
    o_ready  = (state == S_SCAN) && (!o_valid || i_ready);
    o_busy   = (state != S_IDLE);
    o_finish = (state == S_DONE);
  end

  // Job dimensions are frozen for the whole scan.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      num_r <= '0;
      num_k <= '0;
    end else if (start_ok) begin
      num_r <= i_num_r;
      num_k <= i_num_k;
    end
  end

  // Single-entry output register; o_ready guarantees it is free when loading.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      ent     <= '0;
    end else if (store) begin
      o_valid <= 1'b1;
      ent     <= '{r: r, k: k, val: i_data};
    end else if (o_valid && i_ready) begin
      o_valid <= 1'b0;
    end
  end

  // Entry count, sticky overflow and per-group end pointers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_len      <= '0;
      o_overflow <= 1'b0;
      for (int i = 0; i < NUM_GRP; i++) o_ptr[i] <= '0;
    end else if (start_ok) begin
      o_len      <= '0;
      o_overflow <= 1'b0;
      for (int i = 0; i < NUM_GRP; i++) o_ptr[i] <= '0;
    end else begin
      o_len <= len_nxt;
      if (drop) o_overflow <= 1'b1;
      if (accept && last_grp) begin
        for (int i = 0; i < NUM_GRP; i++)
          if (g == G_W'(i)) o_ptr[i] <= len_nxt;
      end
    end
  end
endmodule

// File: tb/tb_sparse_weight_encoder.sv
// Directed + randomized checks of sparse_weight_encoder against a list-based model.
module tb_sparse_weight_encoder;
  localparam int NG = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start_a = 0, start_b = 0, valid = 0, rdy = 0;
  logic [2:0] num_r = 0;
  logic [4:0] num_k = 0;
  logic [7:0] data = 0;

  logic        a_ready, a_valid, a_finish, a_ovf, a_busy;
  logic [2:0]  a_r;
  logic [4:0]  a_k;
  logic [7:0]  a_val;
  logic [10:0] a_ptr [0:NG-1];
  logic [10:0] a_len;
  logic        b_ready, b_valid, b_finish, b_ovf, b_busy;
  logic [2:0]  b_r;
  logic [4:0]  b_k;
  logic [7:0]  b_val;
  logic [10:0] b_ptr [0:NG-1];
  logic [10:0] b_len;

  sparse_weight_encoder #(.NUM_GRP(NG), .MAX_ENTRIES(1024)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_a), .i_num_r(num_r), .i_num_k(num_k),
    .i_valid(valid), .i_data(data), .o_ready(a_ready), .o_valid(a_valid), .i_ready(rdy),
    .o_r(a_r), .o_k(a_k), .o_val(a_val), .o_ptr(a_ptr), .o_len(a_len),
    .o_finish(a_finish), .o_overflow(a_ovf), .o_busy(a_busy));

  sparse_weight_encoder #(.NUM_GRP(NG), .MAX_ENTRIES(2)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_b), .i_num_r(num_r), .i_num_k(num_k),
    .i_valid(valid), .i_data(data), .o_ready(b_ready), .o_valid(b_valid), .i_ready(rdy),
    .o_r(b_r), .o_k(b_k), .o_val(b_val), .o_ptr(b_ptr), .o_len(b_len),
    .o_finish(b_finish), .o_overflow(b_ovf), .o_busy(b_busy));

  bit          sel = 0;
  logic        s_ready, s_valid, s_finish, s_busy, s_ovf;
  logic [2:0]  s_r;
  logic [4:0]  s_k;
  logic [7:0]  s_val;
  logic [10:0] s_len;

  always_comb begin
    s_ready = sel ? b_ready : a_ready;
    s_valid = sel ? b_valid : a_valid;
    s_finish = sel ? b_finish : a_finish;
    s_busy = sel ? b_busy : a_busy;
    s_ovf = sel ? b_ovf : a_ovf;
    s_r = sel ? b_r : a_r;
    s_k = sel ? b_k : a_k;
    s_val = sel ? b_val : a_val;
    s_len = sel ? b_len : a_len;
  end

  logic [15:0] cap[$];
  int          fin_cnt = 0;
  always @(posedge clk) begin
    if (s_valid && rdy) cap.push_back({s_r, s_k, s_val});
    if (s_finish) fin_cnt++;
  end

  int          tests = 0, fails = 0;
  logic [7:0]  w[$];
  logic [15:0] exp_q[$];
  int          exp_ptr[NG];
  int          exp_len;
  bit          exp_ovf;
  int          idx;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: walk the flat weight list group by group, keep nonzeros until capacity.
  task automatic build_model(input int nr, input int nk, input int maxe);
    int base;
    exp_q.delete();
    exp_len = 0;
    exp_ovf = 0;
    for (int gi = 0; gi < NG; gi++) begin
      base = gi * nr * nk;
      for (int e = 0; e < nr * nk; e++) begin
        if (w[base + e] != 8'd0) begin
          if (exp_len < maxe) begin
            exp_q.push_back({3'(e / nk), 5'(e % nk), w[base + e]});
            exp_len++;
          end else begin
            exp_ovf = 1;
          end
        end
      end
      exp_ptr[gi] = exp_len;
    end
  endtask

  task automatic fill_rand(input int n);
    w.delete();
    for (int i = 0; i < n; i++) w.push_back(($urandom % 2) ? 8'($urandom_range(1, 255)) : 8'd0);
  endtask

  task automatic prep(input bit s);
    sel = s;
    cap.delete();
    fin_cnt = 0;
    idx = 0;
  endtask

  task automatic do_start(input int nr, input int nk);
    @(negedge clk);
    num_r = 3'(nr);
    num_k = 5'(nk);
    if (sel) start_b = 1; else start_a = 1;
    @(posedge clk);
    #1;
    start_a = 0;
    start_b = 0;
  endtask

  // Present weights until index upto has been accepted; returns just after that edge.
  task automatic feed(input int upto, input bit rnd_rdy, input bit poke);
    int cyc;
    bit acc;
    cyc = 0;
    while (idx < upto && cyc < 5000) begin
      @(negedge clk);
      valid = 1;
      data = w[idx];
      rdy = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (poke && $urandom_range(0, 7) == 0) begin
        num_r = 3'($urandom);
        num_k = 5'($urandom);
        if (sel) start_b = 1; else start_a = 1;
      end
      #1 acc = s_ready;
      @(posedge clk);
      #1;
      start_a = 0;
      start_b = 0;
      if (acc) idx++;
      cyc++;
    end
    if (idx < upto) chk("feed_timeout", 32'(idx), 32'(upto));
    valid = 0;
  endtask

  task automatic finish_job(input int nr, input int nk, input int maxe, input bit rnd_rdy);
    int cyc;
    logic [10:0] p;
    cyc = 0;
    while (fin_cnt == 0 && cyc < 300) begin
      @(negedge clk);
      rdy = rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
      cyc++;
    end
    chk("finish_seen", 32'(fin_cnt > 0), 32'd1);
    @(negedge clk);
    rdy = 1;
    repeat (3) @(negedge clk);
    chk("finish_pulses", 32'(fin_cnt), 32'd1);
    build_model(nr, nk, maxe);
    chk("entry_count", 32'(cap.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < cap.size(); i++)
      chk($sformatf("entry%0d", i), 32'(cap[i]), 32'(exp_q[i]));
    for (int gi = 0; gi < NG; gi++) begin
      p = sel ? b_ptr[gi] : a_ptr[gi];
      chk($sformatf("ptr%0d", gi), 32'(p), 32'(exp_ptr[gi]));
    end
    chk("len", 32'(s_len), 32'(exp_len));
    chk("overflow", 32'(s_ovf), 32'(exp_ovf));
    chk("busy_idle", 32'(s_busy), 32'd0);
  endtask

  task automatic run_job(input bit s, input int nr, input int nk, input int maxe,
                         input bit rnd_rdy, input bit poke);
    prep(s);
    do_start(nr, nk);
    feed(NG * nr * nk, rnd_rdy, poke);
    finish_job(nr, nk, maxe, rnd_rdy);
  endtask

  task automatic chk_zero_a(input string pfx);
    chk({pfx, "_ready"}, 32'(a_ready), 0);
    chk({pfx, "_valid"}, 32'(a_valid), 0);
    chk({pfx, "_rkv"}, 32'({a_r, a_k, a_val}), 0);
    chk({pfx, "_len"}, 32'(a_len), 0);
    chk({pfx, "_finish"}, 32'(a_finish), 0);
    chk({pfx, "_ovf"}, 32'(a_ovf), 0);
    chk({pfx, "_busy"}, 32'(a_busy), 0);
    for (int gi = 0; gi < NG; gi++) chk($sformatf("%s_ptr%0d", pfx, gi), 32'(a_ptr[gi]), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    #1 chk_zero_a("rst");
    chk("rst_b_len", 32'(b_len), 0);
    @(negedge clk);
    rst_n = 1;

    // Basic example: 4 groups of 1x2
    w = '{8'd5, 8'd0, 8'd0, 8'd0, 8'hFD, 8'd7, 8'd0, 8'd1};
    run_job(0, 1, 2, 1024, 0, 0);
    chk("ex_ptr1", 32'(a_ptr[1]), 1);
    chk("ex_ptr3", 32'(a_ptr[3]), 4);

    // All-zero weights: no entries, finish one cycle after the last accept
    w.delete();
    for (int i = 0; i < NG * 6; i++) w.push_back(8'd0);
    prep(0);
    do_start(2, 3);
    feed(NG * 6, 0, 0);
    chk("zero_drain_nofinish", 32'(a_finish), 0);
    @(posedge clk);
    #1 chk("zero_finish_lat", 32'(a_finish), 1);
    finish_job(2, 3, 1024, 0);

    // Backpressure: entry held stable while i_ready is low
    w = '{8'd9, 8'hFC, 8'd3, 8'd0, 8'd0, 8'd0, 8'd0, 8'd2};
    prep(0);
    do_start(1, 2);
    feed(1, 0, 0);
    repeat (5) begin
      @(negedge clk);
      rdy = 0;
      valid = 1;
      data = w[1];
      #1;
      chk("hold_ready", 32'(a_ready), 0);
      chk("hold_valid", 32'(a_valid), 1);
      chk("hold_entry", 32'({a_r, a_k, a_val}), 32'({3'd0, 5'd0, 8'd9}));
    end
    feed(8, 1, 0);
    finish_job(1, 2, 1024, 1);

    // Capacity 2 with 3 nonzeros
    w = '{8'd0, 8'd4, 8'd0, 8'd0, 8'hFF, 8'd0, 8'd0, 8'd6};
    run_job(1, 1, 2, 2, 0, 0);
    chk("ovf_flag", 32'(b_ovf), 1);
    chk("ovf_len", 32'(b_len), 2);
    chk("ovf_lastptr", 32'(b_ptr[NG-1]), 2);
    fill_rand(NG * 6);
    run_job(1, 2, 3, 2, 1, 0);

    // Empty kernels finish straight from idle
    w.delete();
    prep(0);
    do_start(3, 0);
    chk("nk0_finish_lat", 32'(a_finish), 1);
    finish_job(3, 0, 1024, 0);
    prep(0);
    do_start(0, 5);
    chk("nr0_finish_lat", 32'(a_finish), 1);
    finish_job(0, 5, 1024, 0);

    // Randomized jobs, one with stray start pulses mid-scan
    for (int j = 0; j < 3; j++) begin
      int nr, nk;
      nr = $urandom_range(1, 7);
      nk = $urandom_range(1, 8);
      fill_rand(NG * nr * nk);
      run_job(0, nr, nk, 1024, 1, j == 1);
    end

    // Reset mid-scan after three accepts
    fill_rand(NG * 6);
    w[0] = 8'd11; w[1] = 8'd22; w[2] = 8'd33;
    prep(0);
    do_start(2, 3);
    feed(3, 0, 0);
    @(negedge clk);
    rst_n = 0;
    #1 chk_zero_a("midrst");
    @(negedge clk);
    rst_n = 1;
    fin_cnt = 0;
    repeat (3) @(negedge clk);
    chk("midrst_nofinish", 32'(fin_cnt), 0);
    fill_rand(NG * 6);
    run_job(0, 2, 3, 1024, 1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
